// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit.
// Holds operation and FSM state encodings.
package muldiv_pkg;

   localparam int MD_OP_W = 2;

   typedef enum logic [MD_OP_W-1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } md_op_t;

   typedef enum logic [1:0] {
      MD_IDLE = 2'b00,
      MD_RUN  = 2'b01,
      MD_FIX  = 2'b10
   } md_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of shift-add multiply or restoring divide.
// Ports: div selects divide, acc is the 2*WIDTH accumulator, b the
// multiplicand/divisor magnitude, nxt the accumulator after one step.
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic               div,
   input  logic [2*WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] nxt
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   rem;
   logic [WIDTH-1:0] diff;

   always_comb begin
      // multiply: add into the upper half, then shift right with carry
      sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b} : '0);
      // divide: partial remainder after shifting the accumulator left
      rem  = acc[2*WIDTH-1:WIDTH-1];
      diff = rem[WIDTH-1:0] - b;
      if (div) begin
         if (rem >= {1'b0, b})
            nxt = {diff, acc[WIDTH-2:0], 1'b1};
         else
            nxt = {acc[2*WIDTH-2:0], 1'b0};
      end else begin
         nxt = {sum, acc[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO.
// Ports: clk, reset (sync, active-low), start/op/a/b launch, abort cancels,
// mthi/mtlo/wdata move in, busy/done status, hi/lo results.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [MD_OP_W-1:0] op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               abort,
   input  logic               mthi,
   input  logic               mtlo,
   input  logic [WIDTH-1:0]   wdata,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   hi,
   output logic [WIDTH-1:0]   lo
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   md_state_t          state, state_nxt;
   md_op_t             op_e;
   logic [CW-1:0]      count;
   logic [2*WIDTH-1:0] acc, acc_step, prod;
   logic [WIDTH-1:0]   opb, a_orig, quo, rem;
   logic               is_div, neg_q, neg_r, b_zero;
   logic               sgn, sa, sb, launch;

   assign op_e   = md_op_t'(op);
   assign sgn    = (op_e == MD_MULT) || (op_e == MD_DIV);
   assign sa     = sgn & a[WIDTH-1];
   assign sb     = sgn & b[WIDTH-1];
   assign launch = (state == MD_IDLE) && start && !abort;
   assign busy   = (state != MD_IDLE);

   // sign correction on the magnitude result
   assign prod = neg_q ? -acc : acc;
   assign quo  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   assign rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .div (is_div),
      .acc (acc),
      .b   (opb),
      .nxt (acc_step)
   );

   always_ff @(posedge clk) begin
      if (!reset)
         state <= MD_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         MD_IDLE: if (launch) state_nxt = MD_RUN;
         MD_RUN: begin
            if (abort)
               state_nxt = MD_IDLE;
            else if (count == LAST)
               state_nxt = MD_FIX;
         end
         MD_FIX:  state_nxt = MD_IDLE;
         default: state_nxt = MD_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         hi     <= '0;
         lo     <= '0;
         done   <= 1'b0;
         count  <= '0;
         acc    <= '0;
         opb    <= '0;
         a_orig <= '0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         b_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            MD_IDLE: begin
               if (launch) begin
                  acc    <= {{WIDTH{1'b0}}, (sa ? -a : a)};
                  opb    <= sb ? -b : b;
                  a_orig <= a;
                  is_div <= op_e[1];
                  neg_q  <= sa ^ sb;
                  neg_r  <= sa;
                  b_zero <= (b == '0);
                  count  <= '0;
               end else if (!start) begin
                  // a start in the same cycle swallows the move
                  if (mthi) hi <= wdata;
                  if (mtlo) lo <= wdata;
               end
            end
            MD_RUN: begin
               acc   <= acc_step;
               count <= count + CW'(1);
            end
            MD_FIX: begin
               if (!abort) begin
                  done <= 1'b1;
                  if (!is_div) begin
                     {hi, lo} <= prod;
                  end else if (b_zero) begin
                     hi <= a_orig;
                     lo <= '1;
                  end else begin
                     hi <= rem;
                     lo <= quo;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against an arithmetic model.
// Directed spec vectors first, then a long random phase.
module tb_muldiv_unit;

   localparam int WIDTH = 32;

   logic              clk;
   logic              reset;
   logic              start;
   logic [1:0]        op;
   logic [WIDTH-1:0]  a, b, wdata;
   logic              abort, mthi, mtlo;
   logic              busy, done;
   logic [WIDTH-1:0]  hi, lo;

   int errors = 0;
   int checks = 0;

   logic [WIDTH-1:0] exp_hi, exp_lo;
   logic             exp_busy, exp_done;
   logic [63:0]      pend;
   int               remaining = 0;
   bit               chk_en = 0;

   muldiv_unit #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .abort (abort),
      .mthi  (mthi),
      .mtlo  (mtlo),
      .wdata (wdata),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                  $time);
      end
   endtask

   // {hi, lo} an operation must produce, straight from the arithmetic rules
   function automatic logic [63:0] md_ref(input logic [1:0] o,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
      longint          p;
      longint unsigned pu;
      int              sx, sy;
      sx = $signed(x);
      sy = $signed(y);
      case (o)
         2'd0: begin
            p = longint'(sx) * longint'(sy);
            return p;
         end
         2'd1: begin
            pu = 64'(x) * 64'(y);
            return pu;
         end
         2'd2: begin
            if (y == 0) return {x, 32'hFFFF_FFFF};
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
               return {32'h0, 32'h8000_0000};
            return {32'(sx % sy), 32'(sx / sy)};
         end
         default: begin
            if (y == 0) return {x, 32'hFFFF_FFFF};
            return {x % y, x / y};
         end
      endcase
   endfunction

   // cycle-level expectation: a launch commits WIDTH+1 edges later
   always @(posedge clk) begin
      if (!reset) begin
         exp_hi = 0; exp_lo = 0;
         exp_busy = 0; exp_done = 0;
         remaining = 0;
         chk_en = 1;
      end else if (remaining > 0) begin
         exp_done = 0;
         if (abort) begin
            remaining = 0;
            exp_busy = 0;
         end else begin
            remaining--;
            if (remaining == 0) begin
               {exp_hi, exp_lo} = pend;
               exp_done = 1;
               exp_busy = 0;
            end
         end
      end else begin
         exp_done = 0;
         if (start) begin
            if (!abort) begin
               pend = md_ref(op, a, b);
               remaining = WIDTH + 1;
               exp_busy = 1;
            end
         end else begin
            if (mthi) exp_hi = wdata;
            if (mtlo) exp_lo = wdata;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", 64'(busy), 64'(exp_busy));
         chk("done", 64'(done), 64'(exp_done));
         chk("hi", 64'(hi), 64'(exp_hi));
         chk("lo", 64'(lo), 64'(exp_lo));
      end
   end

   task automatic wait_done(input string name, output int nbusy);
      nbusy = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         if (busy) nbusy++;
         @(negedge clk);
      end
      if (!done) chk({name, "_timeout"}, 64'(done), 64'd1);
   endtask

   task automatic run_op(input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, output int nbusy);
      op = o; a = x; b = y; start = 1;
      @(negedge clk);
      start = 0; mthi = 0; mtlo = 0;
      wait_done("run", nbusy);
   endtask

   initial begin
      int nb, nd;
      reset = 0; start = 1; mthi = 1; mtlo = 0; abort = 0;
      op = 0; a = 0; b = 0; wdata = 32'h55;
      repeat (2) @(negedge clk);
      chk("rst_hi", 64'(hi), 64'h0);
      chk("rst_lo", 64'(lo), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_done", 64'(done), 64'h0);
      reset = 1; start = 0; mthi = 0;
      @(negedge clk);

      chk("pin_mult", md_ref(0, 32'hFFFF_FFFD, 7), 64'hFFFF_FFFF_FFFF_FFEB);
      chk("pin_multu", md_ref(1, 32'hFFFF_FFFD, 7), 64'h6_FFFF_FFEB);
      chk("pin_div", md_ref(2, 32'hFFFF_FFF9, 2), 64'hFFFF_FFFF_FFFF_FFFD);
      chk("pin_divu", md_ref(3, 100, 7), {32'd2, 32'd14});
      chk("pin_div0", md_ref(3, 32'h1234, 0), {32'h1234, 32'hFFFF_FFFF});
      chk("pin_ovf", md_ref(2, 32'h8000_0000, 32'hFFFF_FFFF),
          {32'h0, 32'h8000_0000});

      run_op(2'd0, 32'hFFFF_FFFD, 32'd7, nb);
      chk("mult_busy_cycles", 64'(nb), 64'd33);
      chk("mult", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
      run_op(2'd1, 32'hFFFF_FFFD, 32'd7, nb);
      chk("multu", {hi, lo}, 64'h0000_0006_FFFF_FFEB);
      run_op(2'd2, 32'hFFFF_FFF9, 32'd2, nb);
      chk("div", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op(2'd3, 32'd100, 32'd7, nb);
      chk("divu", {hi, lo}, {32'd2, 32'd14});
      run_op(2'd3, 32'h1234, 32'd0, nb);
      chk("divu_by0", {hi, lo}, {32'h1234, 32'hFFFF_FFFF});
      run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, nb);
      chk("div_ovf", {hi, lo}, {32'h0, 32'h8000_0000});

      // start and mtlo while busy are both ignored
      op = 2'd1; a = 3; b = 5; start = 1;
      @(negedge clk);
      start = 0;
      repeat (4) @(negedge clk);
      op = 2'd3; a = 100; b = 7; start = 1;
      @(negedge clk);
      start = 0; wdata = 32'hAA; mtlo = 1;
      @(negedge clk);
      mtlo = 0;
      wait_done("collide", nb);
      chk("collide", {hi, lo}, {32'd0, 32'd15});

      wdata = 32'h55; mthi = 1;
      run_op(2'd3, 32'd100, 32'd7, nb);
      chk("mthi_vs_start", {hi, lo}, {32'd2, 32'd14});

      wdata = 32'h11; mthi = 1;
      @(negedge clk);
      mthi = 0; wdata = 32'h22; mtlo = 1;
      @(negedge clk);
      mtlo = 0;
      op = 2'd0; a = 5; b = 6; start = 1;
      @(negedge clk);
      start = 0;
      repeat (9) @(negedge clk);
      abort = 1;
      @(negedge clk);
      abort = 0;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_keep", {hi, lo}, {32'h11, 32'h22});
      nd = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) nd++;
         @(negedge clk);
      end
      chk("abort_no_done", 64'(nd), 64'd0);

      op = 2'd3; a = 1000; b = 3; start = 1;
      @(negedge clk);
      start = 0;
      repeat (19) @(negedge clk);
      reset = 0;
      @(negedge clk);
      reset = 1;
      chk("midrst", {hi, lo}, 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      repeat (40) @(negedge clk);

      for (int i = 0; i < 3000; i++) begin
         logic [31:0] r;
         r = $urandom;
         op = r[1:0];
         case ($urandom_range(0, 4))
            0: a = 32'h8000_0000;
            1: a = 0;
            2: a = $urandom_range(0, 200);
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0: b = 0;
            1: b = 32'hFFFF_FFFF;
            2: b = 1;
            3: b = $urandom_range(0, 20);
            default: b = $urandom;
         endcase
         start = ($urandom_range(0, 7) == 0);
         abort = ($urandom_range(0, 63) == 0);
         mthi  = ($urandom_range(0, 15) == 0);
         mtlo  = ($urandom_range(0, 15) == 0);
         wdata = $urandom;
         if (start && abort) begin
            mthi = 0;
            mtlo = 0;
         end
         reset = ($urandom_range(0, 999) != 0);
         @(negedge clk);
      end
      reset = 1; start = 0; abort = 0; mthi = 0; mtlo = 0;
      repeat (40) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
